// File: rtl/flow_sequencer_pkg.sv
// flow_sequencer_pkg: sequencer state and the control-flow opcodes it decodes
package flow_sequencer_pkg;
   typedef enum logic {RUN, HALT} seq_state_e;
   localparam logic [7:0] I_NOP   = 8'h00;
   localparam logic [7:0] I_JMP   = 8'h01;
   localparam logic [7:0] I_JMPI  = 8'h02;
   localparam logic [7:0] I_CALL  = 8'h03;
   localparam logic [7:0] I_CALLI = 8'h04;
   localparam logic [7:0] I_RET   = 8'h05;
   localparam logic [7:0] I_BRA   = 8'h10;
   localparam logic [7:0] I_BC    = 8'h11;
   localparam logic [7:0] I_BNC   = 8'h12;
   localparam logic [7:0] I_BO    = 8'h13;
   localparam logic [7:0] I_BNO   = 8'h14;
   localparam logic [7:0] I_BEQ   = 8'h15;
   localparam logic [7:0] I_BNE   = 8'h16;
   localparam logic [7:0] I_BLES  = 8'h17;
   localparam logic [7:0] I_BLEQ  = 8'h18;
   localparam logic [7:0] I_BLESU = 8'h19;
   localparam logic [7:0] I_BLEQU = 8'h1A;
   localparam logic [7:0] I_BZ    = 8'h1B;
   localparam logic [7:0] I_BNZ   = 8'h1C;
   localparam logic [7:0] I_BI    = 8'h1D;
   localparam logic [7:0] I_BNI   = 8'h1E;
endpackage

// File: rtl/flow_sequencer_return_stack.sv
// return_stack: DEPTH x WIDTH LIFO of call return addresses
module return_stack #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 16
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] sp;
   assign full = sp == (AW + 1)'(DEPTH);
   assign empty = sp == '0;
   assign top_data = mem[AW'(sp - 1'b1)];
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) sp <= '0;
      else if (push && !full) sp <= sp + 1'b1;
      else if (pop && !empty) sp <= sp - 1'b1;
   always_ff @(posedge clk)
      if (push && !full) mem[AW'(sp)] <= push_data;
endmodule

// File: rtl/flow_sequencer.sv
// flow_sequencer: registered program counter with branch resolution, return stack and
// latched interrupt lines consumed by taken BI instructions
module flow_sequencer
   import flow_sequencer_pkg::*;
#(
   parameter int WORD_WIDTH = 32,
   parameter int PC_WIDTH   = 16,
   parameter int CALL_DEPTH = 16,
   parameter int INT_COUNT  = 4
)(
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         instr_valid,
   input  logic [7:0]                   instruction,
   input  logic [WORD_WIDTH-1:0]        top,
   input  logic [WORD_WIDTH-1:0]        second,
   input  logic                         carry,
   input  logic                         overflow,
   input  logic [PC_WIDTH-1:0]          target,
   input  logic [INT_COUNT-1:0]         int_req,
   input  logic [INT_COUNT-1:0]         int_enable,
   input  logic                         fault_clear,
   output logic [PC_WIDTH-1:0]          pc,
   output logic                         taken,
   output logic [$clog2(INT_COUNT)-1:0] int_index,
   output logic                         halted,
   output logic                         stack_overflow,
   output logic                         stack_underflow
);
   localparam int IW = $clog2(INT_COUNT);
   seq_state_e state, state_nxt;
   logic [INT_COUNT-1:0] pending, ready, clr;
   logic [IW-1:0] int_sel;
   logic [PC_WIDTH-1:0] pc_inc, pc_nxt, top_data;
   logic accept, cond, is_br, tk_nxt, push_req, pop_req, full, empty, ovf, unf, fault;
   assign accept = instr_valid && state == RUN;
   assign halted = state == HALT;
   assign pc_inc = pc + 1'b1;
   assign ready = pending & int_enable;
   assign fault = accept && (ovf || unf);
   assign clr = (accept && instruction == I_BI && |ready) ? INT_COUNT'(1) << int_sel : '0;
   return_stack #(.DEPTH(CALL_DEPTH), .WIDTH(PC_WIDTH)) u_stack (
      .clk(clk), .reset_n(reset_n), .push(accept && push_req), .pop(accept && pop_req),
      .push_data(pc_inc), .top_data(top_data), .full(full), .empty(empty)
   );
   // lowest-index enabled pending line wins
   always_comb begin
      int_sel = '0;
      for (int i = INT_COUNT - 1; i >= 0; i--) if (ready[i]) int_sel = IW'(i);
   end
   always_comb begin
      cond = 1'b0;
      is_br = 1'b1;
      case (instruction)
         I_BRA:   cond = 1'b1;
         I_BC:    cond = carry;
         I_BNC:   cond = !carry;
         I_BO:    cond = overflow;
         I_BNO:   cond = !overflow;
         I_BEQ:   cond = second == top;
         I_BNE:   cond = second != top;
         I_BLES:  cond = $signed(second) < $signed(top);
         I_BLEQ:  cond = $signed(second) <= $signed(top);
         I_BLESU: cond = second < top;
         I_BLEQU: cond = second <= top;
         I_BZ:    cond = top == '0;
         I_BNZ:   cond = top != '0;
         I_BI:    cond = |ready;
         I_BNI:   cond = ~|ready;
         default: is_br = 1'b0;
      endcase
   end
   always_comb begin
      pc_nxt = pc_inc;
      tk_nxt = 1'b0;
      push_req = 1'b0;
      pop_req = 1'b0;
      ovf = 1'b0;
      unf = 1'b0;
      case (instruction)
         I_JMPI: {pc_nxt, tk_nxt} = {target, 1'b1};
         I_JMP:  {pc_nxt, tk_nxt} = {PC_WIDTH'(top), 1'b1};
         I_CALL, I_CALLI: begin
            ovf = full;
            push_req = !full;
            tk_nxt = !full;
            pc_nxt = full ? pc : instruction == I_CALLI ? target : PC_WIDTH'(top);
         end
         I_RET: begin
            unf = empty;
            pop_req = !empty;
            tk_nxt = !empty;
            pc_nxt = empty ? pc : top_data;
         end
         default: if (is_br && cond) {pc_nxt, tk_nxt} = {target, 1'b1};
      endcase
   end
   always_comb state_nxt = fault ? HALT : (halted && fault_clear) ? RUN : state;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= RUN;
         pc <= '0;
         taken <= 1'b0;
         int_index <= '0;
         pending <= '0;
         stack_overflow <= 1'b0;
         stack_underflow <= 1'b0;
      end else begin
         state <= state_nxt;
         pending <= (pending & ~clr) | int_req;
         if (accept) begin
            pc <= pc_nxt;
            taken <= tk_nxt;
         end
         if (|clr) int_index <= int_sel;
         if (halted && fault_clear) begin
            stack_overflow <= 1'b0;
            stack_underflow <= 1'b0;
         end else begin
            stack_overflow <= stack_overflow | (accept && ovf);
            stack_underflow <= stack_underflow | (accept && unf);
         end
      end
endmodule

// File: tb/tb_flow_sequencer.sv
// tb_flow_sequencer: directed vectors for flow_sequencer, checked every cycle against a
// queue-based model plus literal expectations
module tb_flow_sequencer;
   import flow_sequencer_pkg::*;
   localparam int DEPTH = 4;
   logic clk = 0, reset_n = 0, instr_valid = 0, carry = 0, overflow = 0, fault_clear = 0;
   logic [7:0] instruction = I_NOP;
   logic [31:0] top = 0, second = 0;
   logic [15:0] target = 0;
   logic [3:0] int_req = 0, int_enable = 0;
   logic [15:0] pc;
   logic [1:0] int_index;
   logic taken, halted, stack_overflow, stack_underflow;
   int errors = 0, checks = 0;
   bit chk_en = 0;
   int m_pc = 0, m_idx = 0;
   bit m_taken = 0, m_halt = 0, m_ov = 0, m_un = 0;
   bit [3:0] m_pend = 0;
   int m_stk[$];

   typedef struct {logic [7:0] op; logic [31:0] tp, sec; logic c, v;} vec_t;
   vec_t vecs [16] = '{
      '{I_BRA, 0, 0, 0, 0}, '{I_BC, 0, 0, 1, 0}, '{I_BC, 0, 0, 0, 0}, '{I_BNC, 0, 0, 0, 0},
      '{I_BO, 0, 0, 0, 1}, '{I_BNO, 0, 0, 0, 1}, '{I_BEQ, 5, 5, 0, 0}, '{I_BNE, 5, 5, 0, 0},
      '{I_BLEQ, 32'hFFFFFFFE, 32'hFFFFFFFE, 0, 0}, '{I_BLES, 7, 7, 0, 0},
      '{I_BLEQU, 1, 32'hFFFFFFFF, 0, 0}, '{I_BZ, 32'h10000, 0, 0, 0},
      '{I_BNZ, 32'h10000, 0, 0, 0}, '{I_JMP, 32'h10234, 0, 0, 0},
      '{I_NOP, 0, 0, 0, 0}, '{8'hEE, 0, 0, 0, 0}
   };

   always #5 clk = ~clk;

   flow_sequencer #(.WORD_WIDTH(32), .PC_WIDTH(16), .CALL_DEPTH(DEPTH), .INT_COUNT(4)) dut (
      .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instruction(instruction),
      .top(top), .second(second), .carry(carry), .overflow(overflow), .target(target),
      .int_req(int_req), .int_enable(int_enable), .fault_clear(fault_clear), .pc(pc),
      .taken(taken), .int_index(int_index), .halted(halted),
      .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: what one clock edge must do, from the architectural rules
   initial forever begin
      bit [3:0] clr;
      bit go;
      int nxt, dest;
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         m_pc = 0; m_idx = 0; m_taken = 0; m_halt = 0; m_ov = 0; m_un = 0; m_pend = 0;
         m_stk.delete();
      end else begin
         clr = 0;
         if (m_halt) begin
            if (fault_clear) begin m_halt = 0; m_ov = 0; m_un = 0; end
         end else if (instr_valid) begin
            nxt = (m_pc + 1) % 65536;
            dest = int'(target);
            case (instruction)
               I_JMPI, I_CALLI, I_BRA: go = 1;
               I_JMP, I_CALL: begin go = 1; dest = int'(top[15:0]); end
               I_RET: go = 1;
               I_BC: go = carry;
               I_BNC: go = !carry;
               I_BO: go = overflow;
               I_BNO: go = !overflow;
               I_BEQ: go = second == top;
               I_BNE: go = second != top;
               I_BLES: go = $signed(second) < $signed(top);
               I_BLEQ: go = $signed(second) <= $signed(top);
               I_BLESU: go = second < top;
               I_BLEQU: go = second <= top;
               I_BZ: go = top == 0;
               I_BNZ: go = top != 0;
               I_BI: go = (m_pend & int_enable) != 0;
               I_BNI: go = (m_pend & int_enable) == 0;
               default: go = 0;
            endcase
            if (instruction == I_CALL || instruction == I_CALLI) begin
               if (m_stk.size() == DEPTH) begin m_ov = 1; m_halt = 1; go = 0; nxt = m_pc; end
               else m_stk.push_back(nxt);
            end
            if (instruction == I_RET) begin
               if (m_stk.size() == 0) begin m_un = 1; m_halt = 1; go = 0; nxt = m_pc; end
               else dest = m_stk.pop_back();
            end
            if (instruction == I_BI && go)
               for (int i = 0; i < 4; i++)
                  if (m_pend[i] && int_enable[i]) begin clr[i] = 1; m_idx = i; break; end
            m_pc = go ? dest : nxt;
            m_taken = go;
         end
         m_pend = (m_pend & ~clr) | int_req;
      end
   end

   always @(negedge clk) if (chk_en) begin
      check("m_pc", pc, m_pc);
      check("m_taken", taken, m_taken);
      check("m_int_index", int_index, m_idx);
      check("m_halted", halted, m_halt);
      check("m_overflow", stack_overflow, m_ov);
      check("m_underflow", stack_underflow, m_un);
   end

   task automatic op(input logic [7:0] ins, input logic [15:0] tgt = 0,
                     input logic [31:0] tp = 0, input logic [31:0] sec = 0);
      instruction = ins; target = tgt; top = tp; second = sec; instr_valid = 1;
      @(negedge clk);
      instr_valid = 0;
   endtask

   task automatic clear_fault();
      fault_clear = 1;
      @(negedge clk);
      fault_clear = 0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      reset_n = 1;
      chk_en = 1;
      check("rst_pc", pc, 0);
      check("rst_taken", taken, 0);
      check("rst_halted", halted, 0);
      check("rst_ovf", stack_overflow, 0);
      check("rst_unf", stack_underflow, 0);
      check("rst_idx", int_index, 0);
      for (int i = 1; i <= 3; i++) begin
         op(I_NOP);
         check("nop_pc", pc, i);
      end
      check("nop_taken", taken, 0);
      op(I_NOP); op(I_NOP);
      check("pc5", pc, 5);
      op(I_JMPI, 16'h40);
      check("jmpi_pc", pc, 16'h40);
      check("jmpi_taken", taken, 1);
      op(I_BLES, 16'h80, 32'd1, 32'hFFFFFFFF);
      check("bles_pc", pc, 16'h80);
      op(I_BLESU, 16'h80, 32'd1, 32'hFFFFFFFF);
      check("blesu_pc", pc, 16'h81);
      check("blesu_taken", taken, 0);
      foreach (vecs[i]) begin
         carry = vecs[i].c; overflow = vecs[i].v;
         op(vecs[i].op, 16'(16'h100 + 3 * i), vecs[i].tp, vecs[i].sec);
      end
      carry = 0; overflow = 0;
      check("jmp_trunc_pc", pc, 16'h0236);
      op(I_JMPI, 16'h10);
      for (int i = 0; i < 4; i++) op(I_CALLI, 16'(16'h11 + i));
      check("calls_pc", pc, 16'h14);
      op(I_CALLI, 16'h50);
      check("ovf_flag", stack_overflow, 1);
      check("ovf_halted", halted, 1);
      check("ovf_pc", pc, 16'h14);
      op(I_JMPI, 16'h99);
      check("halt_hold_pc", pc, 16'h14);
      clear_fault();
      check("clr_halted", halted, 0);
      check("clr_ovf", stack_overflow, 0);
      for (int i = 0; i < 4; i++) begin
         op(I_RET);
         check("ret_pc", pc, 16'h14 - i);
      end
      op(I_RET);
      check("unf_flag", stack_underflow, 1);
      check("unf_pc", pc, 16'h11);
      clear_fault();
      int_enable = 4'b0100; int_req = 4'b0110;
      @(negedge clk);
      int_req = 0;
      op(I_BI, 16'h20);
      check("bi1_taken", taken, 1);
      check("bi1_idx", int_index, 2);
      op(I_BI, 16'h30);
      check("bi2_taken", taken, 0);
      int_enable = 4'hF;
      op(I_BI, 16'h30);
      check("bi3_taken", taken, 1);
      check("bi3_idx", int_index, 1);
      op(I_BNI, 16'h40);
      check("bni_pc", pc, 16'h40);
      int_req = 4'b0001;
      @(negedge clk);
      op(I_BI, 16'h50);
      int_req = 0;
      op(I_BI, 16'h60);
      check("setwins_pc", pc, 16'h60);
      check("setwins_idx", int_index, 0);
      op(I_BI, 16'h70);
      check("drained_pc", pc, 16'h61);
      op(I_JMPI, 16'h100);
      op(I_CALLI, 16'h200);
      op(I_CALLI, 16'h300);
      instruction = I_CALLI; target = 16'h400; instr_valid = 1;
      #2 reset_n = 0;
      #1;
      check("arst_pc", pc, 0);
      check("arst_taken", taken, 0);
      check("arst_halted", halted, 0);
      instr_valid = 0;
      @(negedge clk);
      reset_n = 1;
      op(I_RET);
      check("arst_unf", stack_underflow, 1);
      check("arst_unf_pc", pc, 0);
      clear_fault();
      op(I_JMPI, 16'hFFFF);
      check("wrap_pre", pc, 16'hFFFF);
      op(I_BNZ, 16'h1234, 32'd0);
      check("wrap_pc", pc, 0);
      check("wrap_taken", taken, 0);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
